// File: rtl/vga_dvid_tx.sv
// 640x480@60 timing generator with a 3-bit-per-colour test pattern, followed by
// three DVI TMDS channel encoders whose 10-bit symbols feed an external serializer.
module vga_dvid_tx #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [2:0] blue,
  output logic [9:0] tmds_red,
  output logic [9:0] tmds_green,
  output logic [9:0] tmds_blue,
  output logic [9:0] tmds_clk
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_blank;
  logic [2:0] r_col [3];   // index 0 blue, 1 green, 2 red (DVI channel order)
  logic       w_blank;
  logic       w_hs_act;
  logic       w_vs_act;
  logic [9:0] w_tmds [3];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
    end else begin
      r_hcnt <= r_hcnt + 10'd1;
    end
  end

  assign w_blank  = (r_hcnt >= H_VIS) || (r_vcnt >= V_VIS);
  assign w_hs_act = (r_hcnt >= HS_START) && (r_hcnt < HS_END);
  assign w_vs_act = (r_vcnt >= VS_START) && (r_vcnt < VS_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_blank <= 1'b1;
      r_col[0] <= '0;
      r_col[1] <= '0;
      r_col[2] <= '0;
    end else begin
      r_hsync  <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync  <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_blank  <= w_blank;
      r_col[0] <= w_blank ? 3'd0 : (r_hcnt[7:5] ^ r_vcnt[7:5]);
      r_col[1] <= w_blank ? 3'd0 : r_vcnt[7:5];
      r_col[2] <= w_blank ? 3'd0 : r_hcnt[7:5];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [7:0]        w_d;
      logic [3:0]        w_ones_d;
      logic              w_use_xnor;
      logic [8:0]        w_qm;
      logic [3:0]        w_n1;
      logic [3:0]        w_n0;
      logic signed [4:0] w_n1s;
      logic signed [4:0] w_n0s;
      logic [9:0]        w_sym;
      logic signed [4:0] w_cnt_next;
      logic [1:0]        w_ctrl;
      logic [9:0]        w_ctrl_sym;
      logic signed [4:0] r_cnt;
      logic [9:0]        r_sym;

      assign w_d = {r_col[gi], r_col[gi], r_col[gi][2:1]};

      always_comb begin
        w_ones_d = '0;
        for (int i = 0; i < 8; i++) w_ones_d = w_ones_d + {3'b000, w_d[i]};
      end

      assign w_use_xnor = (w_ones_d > 4'd4) || ((w_ones_d == 4'd4) && !w_d[0]);

      always_comb begin
        w_qm    = '0;
        w_qm[0] = w_d[0];
        for (int i = 1; i < 8; i++)
          w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ w_d[i]) : (w_qm[i-1] ^ w_d[i]);
        w_qm[8] = ~w_use_xnor;
      end

      always_comb begin
        w_n1 = '0;
        for (int i = 0; i < 8; i++) w_n1 = w_n1 + {3'b000, w_qm[i]};
      end

      assign w_n0  = 4'd8 - w_n1;
      assign w_n1s = $signed({1'b0, w_n1});
      assign w_n0s = $signed({1'b0, w_n0});

      // Running disparity chooses between sending q_m as-is or inverted.
      always_comb begin
        w_sym      = '0;
        w_cnt_next = r_cnt;
        if ((r_cnt == 5'sd0) || (w_n1 == w_n0)) begin
          w_sym      = {~w_qm[8], w_qm[8], w_qm[8] ? w_qm[7:0] : ~w_qm[7:0]};
          w_cnt_next = w_qm[8] ? (r_cnt + w_n1s - w_n0s) : (r_cnt + w_n0s - w_n1s);
        end else if (((r_cnt > 5'sd0) && (w_n1 > w_n0)) ||
                     ((r_cnt < 5'sd0) && (w_n0 > w_n1))) begin
          w_sym      = {1'b1, w_qm[8], ~w_qm[7:0]};
          w_cnt_next = r_cnt + (w_qm[8] ? 5'sd2 : 5'sd0) + w_n0s - w_n1s;
        end else begin
          w_sym      = {1'b0, w_qm[8], w_qm[7:0]};
          w_cnt_next = r_cnt - (w_qm[8] ? 5'sd0 : 5'sd2) + w_n1s - w_n0s;
        end
      end

      assign w_ctrl = (gi == 0) ? {r_vsync, r_hsync} : 2'b00;

      always_comb begin
        case (w_ctrl)
          2'b00:   w_ctrl_sym = CTRL_00;
          2'b01:   w_ctrl_sym = CTRL_01;
          2'b10:   w_ctrl_sym = CTRL_10;
          default: w_ctrl_sym = CTRL_11;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_sym <= CTRL_00;
          r_cnt <= '0;
        end else if (r_blank) begin
          r_sym <= w_ctrl_sym;
          r_cnt <= '0;
        end else begin
          r_sym <= w_sym;
          r_cnt <= w_cnt_next;
        end
      end

      assign w_tmds[gi] = r_sym;
    end
  endgenerate

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign blank      = r_blank;
  assign red        = r_col[2];
  assign green      = r_col[1];
  assign blue       = r_col[0];
  assign tmds_blue  = w_tmds[0];
  assign tmds_green = w_tmds[1];
  assign tmds_red   = w_tmds[2];
  assign tmds_clk   = 10'b0000011111;

endmodule

// File: tb/tb_vga_dvid_tx.sv
// Bench for vga_dvid_tx: a full-size instance plus one with a short frame so
// vertical timing and frame wrap are reachable in a short run.
module tb_vga_dvid_tx;

  typedef struct packed {
    logic       blank;
    logic       hs;
    logic       vs;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } pix_t;

  logic       clk;
  logic       reset;
  logic       o_hs [2];
  logic       o_vs [2];
  logic       o_bl [2];
  logic [2:0] o_r  [2];
  logic [2:0] o_g  [2];
  logic [2:0] o_b  [2];
  logic [9:0] o_tr [2];
  logic [9:0] o_tg [2];
  logic [9:0] o_tb [2];
  logic [9:0] o_tc [2];

  int   n_assert = 0;
  int   n_fail   = 0;
  int   t        = 0;
  int   m_vv [2] = '{480, 6};
  int   m_vf [2] = '{10, 2};
  int   m_vs [2] = '{2, 2};
  int   m_vb [2] = '{33, 3};
  pix_t m_prev [2];
  int   m_cnt  [2][3];
  int   disp   [3];
  int   hs_run, hs_fall, vs_run, vs_fall;
  logic hs_prev, vs_prev;
  string ch_name [3] = '{"blue", "green", "red"};

  vga_dvid_tx dut (
    .clk(clk), .reset(reset),
    .hsync(o_hs[0]), .vsync(o_vs[0]), .blank(o_bl[0]),
    .red(o_r[0]), .green(o_g[0]), .blue(o_b[0]),
    .tmds_red(o_tr[0]), .tmds_green(o_tg[0]), .tmds_blue(o_tb[0]), .tmds_clk(o_tc[0])
  );

  vga_dvid_tx #(.V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_v (
    .clk(clk), .reset(reset),
    .hsync(o_hs[1]), .vsync(o_vs[1]), .blank(o_bl[1]),
    .red(o_r[1]), .green(o_g[1]), .blue(o_b[1]),
    .tmds_red(o_tr[1]), .tmds_green(o_tg[1]), .tmds_blue(o_tb[1]), .tmds_clk(o_tc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected timing/pattern state for pixel index p counted from (0,0).
  function automatic pix_t model_pix(input int p, input int k);
    pix_t e;
    int   h, v, vt;
    e  = '0;
    vt = m_vv[k] + m_vf[k] + m_vs[k] + m_vb[k];
    h  = p % 800;
    v  = (p / 800) % vt;
    e.blank = (h >= 640) || (v >= m_vv[k]);
    e.hs    = !((h >= 656) && (h < 752));
    e.vs    = !((v >= m_vv[k] + m_vf[k]) && (v < m_vv[k] + m_vf[k] + m_vs[k]));
    e.r     = e.blank ? 3'd0 : 3'((h / 32) % 8);
    e.g     = e.blank ? 3'd0 : 3'((v / 32) % 8);
    e.b     = e.r ^ e.g;
    return e;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  task automatic m_enc(input logic [2:0] c, input int cnt_in,
                       output logic [9:0] sym, output int cnt_out);
    logic [7:0] d;
    logic [8:0] qm;
    int         ones, n1, n0, qm8;
    bit         xnor_mode;
    d         = 8'((int'(c) * 510 + 7) / 14);   // round(c*255/7)
    ones      = $countones(d);
    xnor_mode = (ones > 4) || ((ones == 4) && (d[0] == 1'b0));
    qm        = '0;
    qm[0]     = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xnor_mode ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xnor_mode;
    n1    = $countones(qm[7:0]);
    n0    = 8 - n1;
    qm8   = qm[8] ? 1 : 0;
    if ((cnt_in == 0) || (n1 == n0)) begin
      sym     = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      cnt_out = cnt_in + ((qm8 == 1) ? (n1 - n0) : (n0 - n1));
    end else if (((cnt_in > 0) && (n1 > n0)) || ((cnt_in < 0) && (n0 > n1))) begin
      sym     = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + 2 * qm8 + n0 - n1;
    end else begin
      sym     = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in - 2 * (1 - qm8) + n1 - n0;
    end
  endtask

  task automatic check_reset(input int k);
    chk($sformatf("d%0d_rst_blank", k), o_bl[k], 1'b1);
    chk($sformatf("d%0d_rst_hsync", k), o_hs[k], 1'b1);
    chk($sformatf("d%0d_rst_vsync", k), o_vs[k], 1'b1);
    chk($sformatf("d%0d_rst_rgb", k), {o_r[k], o_g[k], o_b[k]}, 9'd0);
    chk($sformatf("d%0d_rst_tmds_red", k), o_tr[k], 10'b1101010100);
    chk($sformatf("d%0d_rst_tmds_green", k), o_tg[k], 10'b1101010100);
    chk($sformatf("d%0d_rst_tmds_blue", k), o_tb[k], 10'b1101010100);
    chk($sformatf("d%0d_rst_tmds_clk", k), o_tc[k], 10'b0000011111);
  endtask

  task automatic cycle_check(input int k);
    pix_t       e;
    logic [2:0] cc [3];
    logic [9:0] es [3];
    logic [9:0] os [3];
    cc[0] = m_prev[k].b;  cc[1] = m_prev[k].g;  cc[2] = m_prev[k].r;
    os[0] = o_tb[k];      os[1] = o_tg[k];      os[2] = o_tr[k];
    for (int c = 0; c < 3; c++) begin
      if (m_prev[k].blank) begin
        es[c] = ctrl_sym((c == 0) ? {m_prev[k].vs, m_prev[k].hs} : 2'b00);
        m_cnt[k][c] = 0;
        if (k == 0) disp[c] = 0;
      end else begin
        m_enc(cc[c], m_cnt[k][c], es[c], m_cnt[k][c]);
        if (k == 0) begin
          disp[c] += 2 * $countones(os[c]) - 10;
          chk($sformatf("d0_disparity_%s", ch_name[c]), (disp[c] <= 10) && (disp[c] >= -10), 1'b1);
        end
      end
      chk($sformatf("d%0d_tmds_%s", k, ch_name[c]), os[c], es[c]);
    end
    chk($sformatf("d%0d_tmds_clk", k), o_tc[k], 10'b0000011111);
    e = model_pix(t - 1, k);
    chk($sformatf("d%0d_blank", k), o_bl[k], e.blank);
    chk($sformatf("d%0d_hsync", k), o_hs[k], e.hs);
    chk($sformatf("d%0d_vsync", k), o_vs[k], e.vs);
    chk($sformatf("d%0d_rgb", k), {o_r[k], o_g[k], o_b[k]}, {e.r, e.g, e.b});
    m_prev[k] = e;
  endtask

  task automatic run_phase(input int n);
    for (int k = 0; k < 2; k++) begin
      m_prev[k] = '{blank: 1'b1, hs: 1'b1, vs: 1'b1, r: 3'd0, g: 3'd0, b: 3'd0};
      for (int c = 0; c < 3; c++) m_cnt[k][c] = 0;
    end
    for (int c = 0; c < 3; c++) disp[c] = 0;
    hs_run = 0; hs_fall = -1; hs_prev = 1'b1;
    vs_run = 0; vs_fall = -1; vs_prev = 1'b1;
    t = 0;
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      t++;
      cycle_check(0);
      cycle_check(1);
      if (t == 2) begin
        chk("first_pixel_red", o_tr[0], 10'b0100000000);
        chk("first_pixel_blue", o_tb[0], 10'b0100000000);
      end
      if (t == 3) chk("second_pixel_green", o_tg[0], 10'b1111111111);
      if (t == 658) begin
        chk("hsync_ctrl_blue", o_tb[0], 10'b0101010100);
        chk("hsync_ctrl_red", o_tr[0], 10'b1101010100);
        chk("hsync_ctrl_green", o_tg[0], 10'b1101010100);
      end
      if (!o_hs[0]) begin
        if (hs_prev) begin
          if (hs_fall >= 0) chk("d0_hsync_period", t - hs_fall, 800);
          hs_fall = t;
        end
        hs_run++;
      end else if (!hs_prev) begin
        chk("d0_hsync_width", hs_run, 96);
        hs_run = 0;
      end
      hs_prev = o_hs[0];
      if (!o_vs[1]) begin
        if (vs_prev) begin
          if (vs_fall >= 0) chk("d1_frame_period", t - vs_fall, 10400);
          vs_fall = t;
        end
        vs_run++;
      end else if (!vs_prev) begin
        chk("d1_vsync_width", vs_run, 1600);
        vs_run = 0;
      end
      vs_prev = o_vs[1];
      if (n_fail > 50) break;
    end
    $display("run phase: %0d clk after reset release, %0d assertions so far", t, n_assert);
  endtask

  initial begin
    int n1, n2, rlen;
    reset = 1'b1;
    n1    = 34000 + $urandom_range(0, 799);
    n2    = $urandom_range(1700, 2600);
    rlen  = $urandom_range(1, 4);

    for (int i = 0; i < 3; i++) begin
      step();
      check_reset(0);
      check_reset(1);
    end
    $display("initial reset: held 3 clk");

    run_phase(n1);

    reset = 1'b1;
    for (int i = 0; i < rlen; i++) begin
      step();
      check_reset(0);
      check_reset(1);
    end
    $display("mid-frame reset: held %0d clk", rlen);

    run_phase(n2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
